fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It sits in front of `id_stage`. It generates the next PC, drives the synchronous instruction SRAM, and holds the returned instruction until decode accepts it. It also presents `{inst, pc}` plus exception/delay-slot flags to decode, and applies branch redirects from decode and flush redirects from CP0. It is the producer end of the `fs_to_ds_*` handshake and the consumer end of `br_bus`.

---
 rtl/fetch_stage_pkg.sv | 46 ++++
 rtl/fetch_stage_if.sv | 37 +++
 rtl/fetch_stage_inst_hold_buf.sv | 49 ++++
 rtl/fetch_stage.sv | 163 ++++++++++++++++
 tb/tb_fetch_stage.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// fetch_stage_pkg
//   Shared widths, reset PC, bus layouts and helpers for the instruction-fetch
//   stage of the 5-stage MIPS pipeline.
//
//   Build option: FETCH_ADEL_EN
//     defined   -> fs_ex_bus is 2 bits {adel, bd}; misaligned fetches are flagged.
//     undefined -> fs_ex_bus is 1 bit  {bd}; the PC is trusted to be aligned.
package fetch_stage_pkg;

  localparam int unsigned FsToDsBusWd = 64;
  localparam int unsigned BrBusWd     = 33;

`ifdef FETCH_ADEL_EN
  localparam int unsigned FsExBusWd = 2;
`else
  localparam int unsigned FsExBusWd = 1;
`endif

  // One word before the boot vector so that the first sequential fetch lands on bfc00000.
  localparam logic [31:0] PcResetM4 = 32'hbfbf_fffc;

  // Branch bus from decode, already qualified by decode-valid.
  typedef struct packed {
    logic        is_branch;
    logic        br_taken;
    logic [31:0] br_target;
  } br_bus_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fs_to_ds_t;

  // Source of the next fetch address, in falling priority: flush, branch, pending, sequential.
  typedef enum logic [1:0] {
    SrcSeq,
    SrcFlush,
    SrcBranch,
    SrcPend
  } pc_src_e;

  function automatic logic pc_misaligned(input logic [1:0] pc_lo);
    return pc_lo != 2'b00;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   IF -> ID handshake bundle plus the branch bus coming back from decode.
//
//   Signals:
//     ds_allowin     decode can accept an instruction this cycle
//     br_bus         {is_branch, br_taken, br_target}
//     fs_to_ds_valid IF holds a valid instruction
//     fs_to_ds_bus   {inst, pc}
//     fs_ex_bus      {adel (only with FETCH_ADEL_EN), bd}
//
//   Modports: master = fetch side (producer), slave = decode side (consumer).
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic                   ds_allowin;
  logic [BrBusWd:0]       br_bus;
  logic                   fs_to_ds_valid;
  logic [FsToDsBusWd-1:0] fs_to_ds_bus;
  logic [FsExBusWd-1:0]   fs_ex_bus;

  modport master (
    input  ds_allowin,
    input  br_bus,
    output fs_to_ds_valid,
    output fs_to_ds_bus,
    output fs_ex_bus
  );

  modport slave (
    output ds_allowin,
    output br_bus,
    input  fs_to_ds_valid,
    input  fs_to_ds_bus,
    input  fs_ex_bus
  );

endinterface

// File: rtl/fetch_stage_inst_hold_buf.sv
// inst_hold_buf
//   Holds the instruction returned by the synchronous SRAM while decode is
//   stalled, so the SRAM read port is free to change under a stall.
//
//   Ports:
//     clk, reset  clock; synchronous active-high reset
//     flush       discard any held instruction
//     capture     IF is valid and decode is stalled this cycle
//     release_en  IF -> ID handshake this cycle ("release" is a reserved word)
//     rdata       SRAM read data
//     inst        instruction presented to decode
module inst_hold_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        capture,
  input  logic        release_en,
  input  logic [31:0] rdata,
  output logic [31:0] inst
);

  logic        buf_valid_q, buf_valid_d;
  logic [31:0] inst_buf_q, inst_buf_d;

  always_comb begin
    buf_valid_d = buf_valid_q;
    inst_buf_d  = inst_buf_q;
    if (flush || release_en) begin
      buf_valid_d = 1'b0;
    end else if (capture && !buf_valid_q) begin
      // Only the first stalled cycle sees the fresh read data; later cycles may not.
      buf_valid_d = 1'b1;
      inst_buf_d  = rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      inst_buf_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      inst_buf_q  <= inst_buf_d;
    end
  end

  assign inst = buf_valid_q ? inst_buf_q : rdata;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage of the 5-stage MIPS pipeline. Generates the next
//   PC, drives the synchronous instruction SRAM, holds the returned instruction
//   until decode accepts it, and applies branch (decode) and flush (CP0) redirects.
//
//   Ports:
//     clk, reset       clock; synchronous active-high reset
//     ds_if            fetch_stage_if.master: ds_allowin, br_bus in;
//                      fs_to_ds_valid, fs_to_ds_bus, fs_ex_bus out
//     flush            CP0 exception/eret redirect
//     flush_target     redirect PC on flush
//     inst_sram_en     read request
//     inst_sram_wen    tied 0
//     inst_sram_addr   request address
//     inst_sram_wdata  tied 0
//     inst_sram_rdata  read data, one cycle after the request
//
//   Build option: FETCH_ADEL_EN adds the misaligned-fetch (adel) flag.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.master ds_if,
  input  logic          flush,
  input  logic [31:0]   flush_target,
  output logic          inst_sram_en,
  output logic [3:0]    inst_sram_wen,
  output logic [31:0]   inst_sram_addr,
  output logic [31:0]   inst_sram_wdata,
  input  logic [31:0]   inst_sram_rdata
);

  br_bus_t     br;
  logic        to_fs_valid;
  logic        fs_allowin;
  logic        br_fire;
  logic        issue;
  logic [31:0] seq_pc;
  logic [31:0] nextpc;
  pc_src_e     pc_src;

  logic        fs_valid_q, fs_valid_d;
  logic [31:0] fs_pc_q, fs_pc_d;
  logic        br_pend_q, br_pend_d;
  logic [31:0] pend_target_q, pend_target_d;

  logic        hold_capture;
  logic        hold_release;
  logic [31:0] hold_inst;
  logic [31:0] inst;
  fs_to_ds_t   out_bus;

  assign br = br_bus_t'(ds_if.br_bus);

  // Pre-IF
  assign to_fs_valid = ~reset;
  assign fs_allowin  = ~fs_valid_q | ds_if.ds_allowin;
  assign br_fire     = br.br_taken & ds_if.ds_allowin;
  // A flush redirects even while decode is stalled; the old IF contents are dropped.
  assign issue       = to_fs_valid & (fs_allowin | flush);
  assign seq_pc      = fs_pc_q + 32'd4;

  always_comb begin
    if (flush) begin
      pc_src = SrcFlush;
    end else if (br_fire && fs_valid_q) begin
      pc_src = SrcBranch;
    end else if (br_pend_q) begin
      pc_src = SrcPend;
    end else begin
      // Also covers a branch firing with no delay slot in IF: the slot is fetched first.
      pc_src = SrcSeq;
    end
  end

  always_comb begin
    unique case (pc_src)
      SrcFlush:  nextpc = flush_target;
      SrcBranch: nextpc = br.br_target;
      SrcPend:   nextpc = pend_target_q;
      SrcSeq:    nextpc = seq_pc;
      default:   nextpc = seq_pc;
    endcase
  end

  always_comb begin
    fs_valid_d    = fs_valid_q;
    fs_pc_d       = fs_pc_q;
    br_pend_d     = br_pend_q;
    pend_target_d = pend_target_q;

    if (issue) begin
      fs_valid_d = 1'b1;
      fs_pc_d    = nextpc;
    end else if (fs_valid_q && ds_if.ds_allowin) begin
      fs_valid_d = 1'b0;
    end

    if (flush) begin
      br_pend_d = 1'b0;
    end else if (issue) begin
      if (br_fire && !fs_valid_q) begin
        // Delay slot is being fetched now; the target goes out on the next request.
        br_pend_d     = 1'b1;
        pend_target_d = br.br_target;
      end else begin
        br_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fs_valid_q    <= 1'b0;
      fs_pc_q       <= PcResetM4;
      br_pend_q     <= 1'b0;
      pend_target_q <= '0;
    end else begin
      fs_valid_q    <= fs_valid_d;
      fs_pc_q       <= fs_pc_d;
      br_pend_q     <= br_pend_d;
      pend_target_q <= pend_target_d;
    end
  end

  assign hold_capture = fs_valid_q & ~ds_if.ds_allowin;
  assign hold_release = fs_valid_q & ds_if.ds_allowin;

  inst_hold_buf u_inst_hold_buf (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .capture    (hold_capture),
    .release_en (hold_release),
    .rdata      (inst_sram_rdata),
    .inst       (hold_inst)
  );

`ifdef FETCH_ADEL_EN
  logic adel;

  // A misaligned request is never sent to the SRAM; decode raises AdEL instead.
  assign inst_sram_en    = issue & ~pc_misaligned(nextpc[1:0]);
  assign adel            = pc_misaligned(fs_pc_q[1:0]);
  assign inst            = adel ? 32'h0 : hold_inst;
  assign ds_if.fs_ex_bus = {adel, br.is_branch};
`else
  assign inst_sram_en    = issue;
  assign inst            = hold_inst;
  assign ds_if.fs_ex_bus = br.is_branch;
`endif

  assign inst_sram_wen   = 4'h0;
  assign inst_sram_addr  = nextpc;
  assign inst_sram_wdata = 32'h0;

  assign out_bus.inst          = inst;
  assign out_bus.pc            = fs_pc_q;
  assign ds_if.fs_to_ds_bus    = out_bus;
  assign ds_if.fs_to_ds_valid  = fs_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed, table-driven bench for fetch_stage. Each table row is one clock
//   cycle: inputs are driven after the falling edge, outputs are compared
//   shortly after, before the next rising edge. The bench SRAM returns
//   {16'h1234, addr[15:0]} one cycle after an enabled request and holds its
//   output otherwise; 'garble' overrides the read data with junk.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk;
  logic        reset;
  logic        flush;
  logic [31:0] flush_target;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] inst_sram_rdata;
  logic [31:0] sram_q;
  logic        garble;

  int n_cmp;
  int n_fail;

  fetch_stage_if ds_if ();

  fetch_stage dut (
    .clk             (clk),
    .reset           (reset),
    .ds_if           (ds_if),
    .flush           (flush),
    .flush_target    (flush_target),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .inst_sram_rdata (inst_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (inst_sram_en) sram_q <= {16'h1234, inst_sram_addr[15:0]};
  end
  assign inst_sram_rdata = garble ? 32'hdead_beef : sram_q;

  typedef struct {
    logic        rst;
    logic        allow;
    logic        isbr;
    logic        taken;
    logic [31:0] tgt;
    logic        fl;
    logic [31:0] ftgt;
    logic        garb;
    logic        en;
    logic [31:0] addr;
    logic        chk;    // compare valid/pc/inst this row
    logic        valid;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        bd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic allow, logic isbr, logic taken, logic [31:0] tgt,
                              logic fl, logic [31:0] ftgt, logic garb, logic en,
                              logic [31:0] addr, logic chk, logic valid, logic [31:0] pc,
                              logic [31:0] inst, logic bd);
    vec_t v;
    v.rst = rst; v.allow = allow; v.isbr = isbr; v.taken = taken; v.tgt = tgt;
    v.fl = fl; v.ftgt = ftgt; v.garb = garb; v.en = en; v.addr = addr;
    v.chk = chk; v.valid = valid; v.pc = pc; v.inst = inst; v.bd = bd;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic allow, input logic isbr, input logic taken,
                       input logic [31:0] tgt, input logic fl, input logic [31:0] ftgt,
                       input logic garb);
    reset            = rst;
    ds_if.ds_allowin = allow;
    ds_if.br_bus     = {isbr, taken, tgt};
    flush            = fl;
    flush_target     = ftgt;
    garble           = garb;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    sram_q = 32'h0;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    //       rst  alw  isb  tkn  tgt           fl   ftgt          gar  en   addr          chk  vld  pc            inst          bd
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0, 32'hbfbffffc, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hbfc00000, 1, 0, 32'hbfbffffc, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hbfc00004, 1, 1, 32'hbfc00000, 32'h12340000, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hbfc00008, 1, 1, 32'hbfc00004, 32'h12340004, 0));
    // 3-cycle stall; SRAM data goes bad after the first stalled cycle
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 1, 32'hbfc00008, 32'h12340008, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hbfc00008, 32'h12340008, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        1, 0, 32'h0,        1, 1, 32'hbfc00008, 32'h12340008, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'hbfc0000c, 1, 1, 32'hbfc00008, 32'h12340008, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hbfc00010, 1, 1, 32'hbfc0000c, 32'h1234000c, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hbfc00014, 1, 1, 32'hbfc00010, 32'h12340010, 0));
    // branch with delay slot already in IF
    vecs.push_back(mk(0, 1, 1, 1, 32'hbfc00100, 0, 32'h0,        0, 1, 32'hbfc00100, 1, 1, 32'hbfc00014, 32'h12340014, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hbfc00104, 1, 1, 32'hbfc00100, 32'h12340100, 0));
    // reset mid-operation
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 0, 32'hbfbffffc, 32'h0,        0));
    // branch fires with IF empty: delay slot first, then the target
    vecs.push_back(mk(0, 1, 1, 1, 32'hbfc00100, 0, 32'h0,        0, 1, 32'hbfc00000, 1, 0, 32'hbfbffffc, 32'h0,        1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hbfc00100, 1, 1, 32'hbfc00000, 32'h12340000, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hbfc00104, 1, 1, 32'hbfc00100, 32'h12340100, 0));
    // set br_pend again, then flush together with br_fire
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 1, 1, 1, 32'hbfc00100, 0, 32'h0,        0, 1, 32'hbfc00000, 1, 0, 32'hbfbffffc, 32'h0,        1));
    vecs.push_back(mk(0, 1, 1, 1, 32'hbfc00200, 1, 32'hbfc00380, 0, 1, 32'hbfc00380, 1, 1, 32'hbfc00000, 32'h12340000, 1));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hbfc00384, 1, 1, 32'hbfc00380, 32'h12340380, 0));
    // flush while the hold buffer is full must drop the buffered instruction
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 1, 32'hbfc00384, 32'h12340384, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'hbfc00400, 1, 1, 32'hbfc00400, 1, 1, 32'hbfc00384, 32'h12340384, 0));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        1, 1, 32'hbfc00400, 32'h12340400, 0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        1, 1, 32'hbfc00404, 1, 1, 32'hbfc00400, 32'h12340400, 0));
    // flush on the first cycle out of reset
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h0,        0, 0, 32'h0,        0, 0, 32'h0,        32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'hbfc00380, 0, 1, 32'hbfc00380, 1, 0, 32'hbfbffffc, 32'h0,        0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        0, 32'h0,        0, 1, 32'hbfc00384, 1, 1, 32'hbfc00380, 32'h12340380, 0));

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].allow, vecs[i].isbr, vecs[i].taken, vecs[i].tgt, vecs[i].fl,
            vecs[i].ftgt, vecs[i].garb);
      #2;
      cmp($sformatf("row%0d en", i), {31'h0, inst_sram_en}, {31'h0, vecs[i].en});
      if (vecs[i].en) cmp($sformatf("row%0d addr", i), inst_sram_addr, vecs[i].addr);
      cmp($sformatf("row%0d bd", i), {31'h0, ds_if.fs_ex_bus[0]}, {31'h0, vecs[i].bd});
      if (vecs[i].chk) begin
        cmp($sformatf("row%0d valid", i), {31'h0, ds_if.fs_to_ds_valid}, {31'h0, vecs[i].valid});
        cmp($sformatf("row%0d pc", i), ds_if.fs_to_ds_bus[31:0], vecs[i].pc);
        if (vecs[i].valid) cmp($sformatf("row%0d inst", i), ds_if.fs_to_ds_bus[63:32], vecs[i].inst);
      end
    end

    // Longer stall holding pc bfc00384, then resume at bfc00388.
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, (k != 0));
      #2;
      cmp($sformatf("stall%0d en", k), {31'h0, inst_sram_en}, 32'h0);
      cmp($sformatf("stall%0d pc", k), ds_if.fs_to_ds_bus[31:0], 32'hbfc00384);
      cmp($sformatf("stall%0d inst", k), ds_if.fs_to_ds_bus[63:32], 32'h12340384);
      cmp($sformatf("stall%0d wen", k), {28'h0, inst_sram_wen}, 32'h0);
      cmp($sformatf("stall%0d wdata", k), inst_sram_wdata, 32'h0);
    end
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    #2;
    cmp("resume en", {31'h0, inst_sram_en}, 32'h1);
    cmp("resume addr", inst_sram_addr, 32'hbfc00388);
    cmp("resume inst", ds_if.fs_to_ds_bus[63:32], 32'h12340384);

`ifdef FETCH_ADEL_EN
    // Misaligned flush target: no SRAM request, then adel with inst forced to 0.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'hbfc00382, 1'b0);
    #2;
    cmp("adel en", {31'h0, inst_sram_en}, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #2;
    cmp("adel ex_bus", {30'h0, ds_if.fs_ex_bus}, 32'h2);
    cmp("adel inst", ds_if.fs_to_ds_bus[63:32], 32'h0);
    cmp("adel pc", ds_if.fs_to_ds_bus[31:0], 32'hbfc00382);
    cmp("adel valid", {31'h0, ds_if.fs_to_ds_valid}, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
